// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants, ALU/immediate enums and helpers.
// Ports: none (package). Used by data_path and reg_file.
package riscv_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ir, input imm_fmt_t fmt);
        case (fmt)
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   return {ir[31:12], 12'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction
    // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
    function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two async read ports, one sync write port, async active-low reset.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i (write), raddr1_i/raddr2_i -> rdata1_o/rdata2_o (read).
module reg_file
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    logic [XLEN-1:0] regs_q [NREGS];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
    // x0 is never written, but the read is also forced to zero so it cannot depend on storage
    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/data_path.sv
// data_path: single-cycle RV32I integer datapath (PC, register file, immediates, ALU, branch/jump).
// Ports: clk, rst (async active-low), instruction_word, initialPCval (reset PC), pause (stall);
//        Addition_result (PC+4), Alu_Result (ALU output), RF_WRITING (register write commits).
module data_path
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction_word,
    input  logic [XLEN-1:0] initialPCval,
    input  logic            pause,
    output logic [XLEN-1:0] Addition_result,
    output logic [XLEN-1:0] Alu_Result,
    output logic            RF_WRITING
);
    logic [XLEN-1:0] pc_q, pc_d, next_pc, imm, rs1, rs2, op_a, op_b, target;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [4:0] rd;
    imm_fmt_t fmt;
    alu_op_t op;
    logic a_pc, a_zero, b_rs2, writes_rd, is_branch, is_jal, is_jalr, taken;
    assign opcode = instruction_word[6:0];
    assign f3     = instruction_word[14:12];
    assign rd     = instruction_word[11:7];
    always_comb begin
        fmt       = IMM_I;
        op        = ALU_ADD;
        a_pc      = 1'b0;
        a_zero    = 1'b0;
        b_rs2     = 1'b0;
        writes_rd = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OPC_LUI:    begin fmt = IMM_U; a_zero = 1'b1; writes_rd = 1'b1; end
            OPC_AUIPC:  begin fmt = IMM_U; a_pc = 1'b1; writes_rd = 1'b1; end
            OPC_JAL:    begin fmt = IMM_J; a_pc = 1'b1; writes_rd = 1'b1; is_jal = 1'b1; end
            OPC_JALR:   begin writes_rd = 1'b1; is_jalr = 1'b1; end
            OPC_BRANCH: begin fmt = IMM_B; b_rs2 = 1'b1; op = ALU_SUB; is_branch = 1'b1; end
            // only SRAI uses bit 30 among OP-IMM; ADDI with a negative immediate must stay ADD
            OPC_OPIMM:  begin writes_rd = 1'b1; op = alu_dec(f3, f3 == F3_SR && instruction_word[30]); end
            OPC_OP:     begin writes_rd = 1'b1; b_rs2 = 1'b1; op = alu_dec(f3, instruction_word[30]); end
            default:    ;
        endcase
    end
    assign imm  = imm_gen(instruction_word, fmt);
    assign op_a = a_zero ? '0 : (a_pc ? pc_q : rs1);
    assign op_b = b_rs2 ? rs2 : imm;
    assign Alu_Result      = alu(op, op_a, op_b);
    assign Addition_result = pc_q + 32'd4;
    assign target          = pc_q + imm;
    always_comb begin
        case (f3)
            F3_BEQ:  taken = rs1 == rs2;
            F3_BNE:  taken = rs1 != rs2;
            F3_BLT:  taken = $signed(rs1) < $signed(rs2);
            F3_BGE:  taken = $signed(rs1) >= $signed(rs2);
            F3_BLTU: taken = rs1 < rs2;
            F3_BGEU: taken = rs1 >= rs2;
            default: taken = 1'b0;
        endcase
    end
    assign next_pc = is_jalr ? {Alu_Result[XLEN-1:1], 1'b0} :
                     (is_jal || (is_branch && taken)) ? target : Addition_result;
    assign pc_d       = pause ? pc_q : next_pc;
    assign RF_WRITING = writes_rd & (rd != 5'd0) & ~pause & rst;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= initialPCval;
        else      pc_q <= pc_d;
    end
    reg_file u_rf (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (RF_WRITING),
        .waddr_i  (rd),
        .wdata_i  ((is_jal || is_jalr) ? Addition_result : Alu_Result),
        .raddr1_i (instruction_word[19:15]),
        .raddr2_i (instruction_word[24:20]),
        .rdata1_o (rs1),
        .rdata2_o (rs2)
    );
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench for data_path; register contents are observed through ADDI x0,xN,0 probes.
module tb_data_path;
    logic        clk, rst, pause;
    logic [31:0] instruction_word, initialPCval, Addition_result, Alu_Result;
    logic        RF_WRITING;
    int n_checks = 0;
    int n_errs   = 0;
    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        wr;
        bit          chk_alu;
    } exp_t;
    exp_t sb[$];
    data_path dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_word (instruction_word),
        .initialPCval     (initialPCval),
        .pause            (pause),
        .Addition_result  (Addition_result),
        .Alu_Result       (Alu_Result),
        .RF_WRITING       (RF_WRITING)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    // Called just after a falling edge: drive, push expectation, sample mid-low-phase, then wait a full cycle.
    task automatic step(input string tag, input logic [31:0] ir, input logic p,
                        input logic [31:0] ealu, input logic [31:0] epc4, input logic ewr, input bit ca);
        exp_t e, g;
        instruction_word = ir;
        pause = p;
        e.tag = tag; e.alu = ealu; e.pc4 = epc4; e.wr = ewr; e.chk_alu = ca;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        if (g.chk_alu) check({g.tag, ".alu"}, Alu_Result, g.alu);
        check({g.tag, ".pc4"}, Addition_result, g.pc4);
        check({g.tag, ".wr"}, {31'b0, RF_WRITING}, {31'b0, g.wr});
        @(negedge clk);
    endtask
    initial begin
        rst = 1'b0;
        pause = 1'b0;
        initialPCval = 32'h0;
        instruction_word = 32'h00A00113;
        @(negedge clk);
        check("rst.pc4", Addition_result, 32'd4);
        check("rst.wr", {31'b0, RF_WRITING}, 32'd0);
        check("rst.alu", Alu_Result, 32'd10);
        @(negedge clk);
        check("rst.hold_pc4", Addition_result, 32'd4);
        rst = 1'b1;
        step("addi_x2",   32'h00A00113, 0, 32'd10,       32'd4,  1, 1);
        step("addi_x3",   32'h00E00193, 0, 32'd14,       32'd8,  1, 1);
        step("lui_x10",   32'h0000F537, 0, 32'h0000F000, 32'd12, 1, 1);
        step("beq_taken", 32'h00028463, 0, 32'd0,        32'd16, 0, 1);
        step("jalr_x16",  32'h00718867, 0, 32'd21,       32'd24, 1, 1);
        step("probe_x16", 32'h00080013, 0, 32'd24,       32'd24, 0, 1);
        step("probe_x3",  32'h00018013, 0, 32'd14,       32'd28, 0, 1);
        step("probe_x10", 32'h00050013, 0, 32'h0000F000, 32'd32, 0, 1);
        step("sub_x4",    32'h40310233, 0, 32'hFFFFFFFC, 32'd36, 1, 1);
        step("sra_x6",    32'h40225333, 0, 32'hFFFFFFFF, 32'd40, 1, 1);
        step("jal_x0",    32'hFE9FF06F, 0, 32'd16,       32'd44, 0, 1);
        step("sltu_x7",   32'h004033B3, 0, 32'd1,        32'd20, 1, 1);
        step("slt_x8",    32'h00022433, 0, 32'd1,        32'd24, 1, 1);
        step("bltu_nt",   32'h00026463, 0, 32'hFFFFFFFC, 32'd28, 0, 1);
        step("pause",     32'h06300113, 1, 32'd99,       32'd32, 0, 1);
        step("probe_x2",  32'h00010013, 0, 32'd10,       32'd32, 0, 1);
        step("auipc_x9",  32'h00001497, 0, 32'h00001020, 32'd36, 1, 1);
        step("lw_nop",    32'h00002583, 0, 32'd0,        32'd40, 0, 0);
        step("slli_x12",  32'h00311613, 0, 32'd80,       32'd44, 1, 1);
        step("xori_x13",  32'hFFF14693, 0, 32'hFFFFFFF5, 32'd48, 1, 1);
        initialPCval = 32'h100;
        instruction_word = 32'h00A00113;
        rst = 1'b0;
        #2;
        check("midrst.pc4", Addition_result, 32'h104);
        check("midrst.wr", {31'b0, RF_WRITING}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("post_x2",  32'h00010013, 0, 32'd0, 32'h104, 0, 1);
        step("post_x10", 32'h00050013, 0, 32'd0, 32'h108, 0, 1);
        step("post_x16", 32'h00080013, 0, 32'd0, 32'h10C, 0, 1);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
